// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default word width and mux selection modes.
package cpu_pkg;

  localparam int WORD_W  = 16;

  // Selection modes for the stream multiplexer
  localparam int SEL_EXT = 0;
  localparam int SEL_RR  = 1;

  // Advance a channel index by one, wrapping from n-1 back to 0
  function automatic int wrapInc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nto1_stream_rr_arbiter.sv
// Rotate-priority encoder: grants the first requester at or after ptr,
// searching upward and wrapping from N-1 to 0. Purely combinational.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  int idx;

  // Scan all N positions starting from ptr; the first active request wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-to-1 word multiplexer with a one-entry registered output and valid/ready
// handshake. Channel choice is either an external select or round-robin.
module mux_nto1_stream
  import cpu_pkg::*;
#(
  parameter  int WIDTH    = WORD_W,
  parameter  int N_IN     = 4,
  parameter  int SEL_MODE = SEL_EXT,
  localparam int SEL_W    = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  logic             load;
  logic             gntVld;
  logic [SEL_W-1:0] gntIdx;
  logic [WIDTH-1:0] gntWord;

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q,  outData_d;
  logic [SEL_W-1:0] outSel_q,   outSel_d;

  // The slot can take a word when it is empty or is being drained this cycle
  assign load = ~outValid_q | out_ready;

  generate
    if (SEL_MODE == SEL_RR) begin : gRr
      logic [SEL_W-1:0] rrPtr_q, rrPtr_d;
      logic             arbVld;
      logic [SEL_W-1:0] arbIdx;

      rr_arbiter #(.N(N_IN)) uArb (
        .req     (in_valid),
        .ptr     (rrPtr_q),
        .gnt_vld (arbVld),
        .gnt_idx (arbIdx)
      );

      // Arbiter result only becomes a grant when the output slot can load
      always_comb begin
        gntVld = arbVld & load;
        gntIdx = arbIdx;
      end

      // Pointer moves just past the granted channel, only on a transfer
      always_comb begin
        rrPtr_d = rrPtr_q;
        if (gntVld) begin
          rrPtr_d = SEL_W'(wrapInc(int'(gntIdx), N_IN));
        end
      end

      // Round-robin pointer register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rrPtr_q <= '0;
        end else begin
          rrPtr_q <= rrPtr_d;
        end
      end
    end else begin : gExt
      // External select grants only an in-range, valid channel while loadable
      always_comb begin
        gntVld = 1'b0;
        gntIdx = sel;
        for (int k = 0; k < N_IN; k++) begin
          if (sel == SEL_W'(k) && in_valid[k]) begin
            gntVld = load;
          end
        end
      end
    end
  endgenerate

  // Pick the granted channel's word out of the packed input bus
  always_comb begin
    gntWord = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (gntIdx == SEL_W'(k)) begin
        gntWord = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot accept for the granted channel, forced low while in reset
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (rst_n && gntVld && gntIdx == SEL_W'(k)) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  // Output slot next state: load replaces, drain empties, stall holds
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    if (gntVld) begin
      outValid_d = 1'b1;
      outData_d  = gntWord;
      outSel_d   = gntIdx;
    end else if (load) begin
      outValid_d = 1'b0;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSel_q   <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_sel   = outSel_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: three instances share one stimulus stream
// (external select N=4, round-robin N=4, external select N=3).
module tb_mux_nto1_stream;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  sel;
  } exp_t;

  typedef struct packed {
    logic [3:0] v;
    logic [1:0] s;
    logic       r;
    logic [3:0] expReady0;
    logic [3:0] expReady1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  inValid;
  logic [63:0] inData;
  logic [1:0]  sel;
  logic        outReady;

  logic [3:0]  inReady0, inReady1;
  logic [2:0]  inReady2;
  logic        outValid0, outValid1, outValid2;
  logic [15:0] outData0, outData1, outData2;
  logic [1:0]  outSel0, outSel1, outSel2;

  int nChecks = 0;
  int nBad    = 0;

  int         mValid [3];
  logic [1:0] mPtr;
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];

  always #5 clk = ~clk;

  mux_nto1_stream #(.WIDTH(16), .N_IN(4), .SEL_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady0), .sel(sel), .out_valid(outValid0),
    .out_data(outData0), .out_sel(outSel0), .out_ready(outReady));

  mux_nto1_stream #(.WIDTH(16), .N_IN(4), .SEL_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady1), .sel(sel), .out_valid(outValid1),
    .out_data(outData1), .out_sel(outSel1), .out_ready(outReady));

  mux_nto1_stream #(.WIDTH(16), .N_IN(3), .SEL_MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2:0]), .in_data(inData[47:0]),
    .in_ready(inReady2), .sel(sel), .out_valid(outValid2),
    .out_data(outData2), .out_sel(outSel2), .out_ready(outReady));

  function automatic logic [3:0] getReady(input int d);
    case (d)
      0:       return inReady0;
      1:       return inReady1;
      default: return {1'b0, inReady2};
    endcase
  endfunction

  function automatic logic getValid(input int d);
    case (d)
      0:       return outValid0;
      1:       return outValid1;
      default: return outValid2;
    endcase
  endfunction

  function automatic logic [15:0] getData(input int d);
    case (d)
      0:       return outData0;
      1:       return outData1;
      default: return outData2;
    endcase
  endfunction

  function automatic logic [1:0] getSel(input int d);
    case (d)
      0:       return outSel0;
      1:       return outSel1;
      default: return outSel2;
    endcase
  endfunction

  function automatic int qSize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qPeek(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qPop(input int d);
    exp_t e;
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic qPush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Reference grant: -1 when no channel is granted this cycle
  function automatic int modelGrant(input int d);
    int n;
    int idx;
    n = (d == 2) ? 3 : 4;
    if (!(mValid[d] == 0 || outReady)) return -1;
    if (d == 1) begin
      for (int i = 0; i < 4; i++) begin
        idx = (int'(mPtr) + i) % 4;
        if (inValid[idx]) return idx;
      end
      return -1;
    end
    if (int'(sel) < n && inValid[sel]) return int'(sel);
    return -1;
  endfunction

  task automatic resetModel();
    for (int d = 0; d < 3; d++) mValid[d] = 0;
    mPtr = 2'd0;
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus, entered and left at a falling edge
  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] dat,
                               input logic [1:0] s, input logic r);
    int   g;
    logic drain;
    exp_t e;
    inValid  = v;
    inData   = dat;
    sel      = s;
    outReady = r;
    #1;
    for (int d = 0; d < 3; d++) begin
      g = modelGrant(d);
      checkOutput($sformatf("in_ready dut%0d", d), 64'(getReady(d)),
                  (g >= 0) ? 64'(1 << g) : 64'd0);
      checkOutput($sformatf("out_valid dut%0d", d), 64'(getValid(d)), 64'(mValid[d]));
      if (mValid[d] != 0) begin
        if (qSize(d) == 0) begin
          checkOutput($sformatf("scoreboard empty dut%0d", d), 64'd1, 64'd0);
        end else begin
          e = qPeek(d);
          checkOutput($sformatf("out_data dut%0d", d), 64'(getData(d)), 64'(e.data));
          checkOutput($sformatf("out_sel dut%0d", d), 64'(getSel(d)), 64'(e.sel));
        end
      end
      drain = (mValid[d] != 0) && r;
      if (drain && qSize(d) != 0) qPop(d);
      if (g >= 0) begin
        e.data = dat[g*16 +: 16];
        e.sel  = 2'(g);
        qPush(d, e);
        mValid[d] = 1;
        if (d == 1) mPtr = (g == 3) ? 2'd0 : 2'(g + 1);
      end else if (drain) begin
        mValid[d] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    inValid  = 4'd0;
    outReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
  endtask

  vec_t vecs [12];
  int   rrSeq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n    = 1'b0;
    inValid  = 4'd0;
    inData   = 64'd0;
    sel      = 2'd0;
    outReady = 1'b0;
    resetModel();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    checkOutput("reset out_valid dut0", 64'(outValid0), 64'd0);
    checkOutput("reset out_data dut0", 64'(outData0), 64'd0);
    checkOutput("reset out_sel dut1", 64'(outSel1), 64'd0);
    checkOutput("reset out_data dut1", 64'(outData1), 64'd0);

    // Single BEEF transfer from channel 2 with one cycle of latency
    applyStimulus(4'b0100, 64'h0000_BEEF_0000_0000, 2'd2, 1'b1);
    checkOutput("beef out_valid", 64'(outValid0), 64'd1);
    checkOutput("beef out_data", 64'(outData0), 64'hBEEF);
    checkOutput("beef out_sel", 64'(outSel0), 64'd2);
    checkOutput("beef rr out_data", 64'(outData1), 64'hBEEF);

    // Table: wrap, no-grant select, backpressure, release, drain, sel out of range
    vecs[0]  = '{v: 4'b0100, s: 2'd2, r: 1'b1, expReady0: 4'b0100, expReady1: 4'b0100};
    vecs[1]  = '{v: 4'b0011, s: 2'd1, r: 1'b1, expReady0: 4'b0010, expReady1: 4'b0001};
    vecs[2]  = '{v: 4'b0011, s: 2'd0, r: 1'b1, expReady0: 4'b0001, expReady1: 4'b0010};
    vecs[3]  = '{v: 4'b0001, s: 2'd1, r: 1'b1, expReady0: 4'b0000, expReady1: 4'b0001};
    vecs[4]  = '{v: 4'b1111, s: 2'd3, r: 1'b0, expReady0: 4'b1000, expReady1: 4'b0000};
    vecs[5]  = '{v: 4'b1111, s: 2'd3, r: 1'b0, expReady0: 4'b0000, expReady1: 4'b0000};
    vecs[6]  = '{v: 4'b1111, s: 2'd3, r: 1'b0, expReady0: 4'b0000, expReady1: 4'b0000};
    vecs[7]  = '{v: 4'b1111, s: 2'd0, r: 1'b1, expReady0: 4'b0001, expReady1: 4'b0010};
    vecs[8]  = '{v: 4'b0000, s: 2'd0, r: 1'b1, expReady0: 4'b0000, expReady1: 4'b0000};
    vecs[9]  = '{v: 4'b0000, s: 2'd0, r: 1'b1, expReady0: 4'b0000, expReady1: 4'b0000};
    vecs[10] = '{v: 4'b1000, s: 2'd3, r: 1'b0, expReady0: 4'b1000, expReady1: 4'b1000};
    vecs[11] = '{v: 4'b1000, s: 2'd3, r: 1'b1, expReady0: 4'b1000, expReady1: 4'b1000};

    doReset();
    for (int i = 0; i < 12; i++) begin
      inValid  = vecs[i].v;
      sel      = vecs[i].s;
      outReady = vecs[i].r;
      #1;
      checkOutput($sformatf("vec%0d ready dut0", i), 64'(inReady0), 64'(vecs[i].expReady0));
      checkOutput($sformatf("vec%0d ready dut1", i), 64'(inReady1), 64'(vecs[i].expReady1));
      applyStimulus(vecs[i].v, {$urandom, $urandom}, vecs[i].s, vecs[i].r);
    end

    // Round-robin with every channel valid: one word per clock, rotating
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1111, {$urandom, $urandom}, 2'd0, 1'b1);
      checkOutput($sformatf("rr step%0d out_sel", i), 64'(outSel1), 64'(rrSeq[i]));
      checkOutput($sformatf("rr step%0d out_valid", i), 64'(outValid1), 64'd1);
    end

    // Asynchronous reset in the middle of a cycle while words are held
    inValid  = 4'b1111;
    outReady = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid dut1", 64'(outValid1), 64'd0);
    checkOutput("async rst out_data dut1", 64'(outData1), 64'd0);
    checkOutput("async rst out_sel dut1", 64'(outSel1), 64'd0);
    checkOutput("async rst out_valid dut0", 64'(outValid0), 64'd0);
    checkOutput("async rst in_ready dut0", 64'(inReady0), 64'd0);
    checkOutput("async rst in_ready dut1", 64'(inReady1), 64'd0);
    checkOutput("async rst in_ready dut2", 64'(inReady2), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();

    // After reset the round-robin pointer restarts from channel 0
    applyStimulus(4'b1111, {$urandom, $urandom}, 2'd0, 1'b1);
    checkOutput("post rst rr out_sel", 64'(outSel1), 64'd0);
    applyStimulus(4'b0000, 64'd0, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
